multi_phase_signal_ctrl: RTL
============================

# multi_phase_signal_ctrl

Parametrised N-phase traffic signal controller. It cycles through NUM_PHASES approaches with a per-phase green / extension / yellow sequence and an optional per-phase all-red pedestrian walk interval. The prescaler, interval timer, programmable interval table and per-phase walk latches are integrated in one block. It sits after the debounce and synchronize stages and drives the signal LEDs directly.

## Interface
- NUM_PHASES, 2: number of approaches; legal range 2..8.
- TW, 4: interval width in ticks; minimum 3.
- TICK_DIV, 50000000: clk cycles per timer tick; minimum 2.
- PW (localparam): max(1, $clog2(NUM_PHASES)).

- clk  in  1  system clock; all state on rising edge.
- g_reset  in  1  asynchronous, active-low reset.
- sensor  in  NUM_PHASES  vehicle present per phase; synchronous level.
- walk_req  in  NUM_PHASES  pedestrian request per phase; synchronous, ≥1-cycle pulse.
- prog_en  in  1  one-cycle write strobe for the interval table.
- prog_sel  in  2  table entry: 0 base green, 1 extension, 2 yellow, 3 walk.
- prog_val  in  TW  interval value in ticks.
- green  out  NUM_PHASES  one-hot green lamp for the active phase.
- yellow  out  NUM_PHASES  one-hot yellow lamp for the active phase.
- walk  out  NUM_PHASES  one-hot walk lamp for the active phase.
- phase  out  PW  index of the active phase.

## Operation
- States: GREEN, GREEN_EXT, YELLOW, WALK. The phase counter wraps from NUM_PHASES-1 to 0.
- GREEN lasts base ticks. At its terminal tick:
  - If sensor[phase]=1, go to GREEN_EXT for ext ticks.
  - Otherwise go to YELLOW.
  - Extension is granted at most once per green, and only if ext≠0.
- GREEN_EXT ends in YELLOW. The green lamp stays on during GREEN_EXT.
- YELLOW lasts yellow ticks. At its terminal tick:
  - If walk_lat[phase]=1, go to WALK with the same phase.
  - Otherwise go to GREEN of phase+1.
- WALK lasts walk ticks. green and yellow are all 0, and walk[phase]=1. It then goes to GREEN of phase+1.
- Walk latches:
  - walk_lat[p] is set by walk_req[p].
  - walk_lat[p] is cleared on the cycle WALK for phase p is entered.
  - If set and clear coincide, set wins.
  - A request arriving during its own WALK is kept for the next cycle round.
- Interval table and programming:
  - The table is four TW-bit registers. Reset defaults: base=6, ext=3, yellow=2, walk=3.
  - prog_en writes prog_val into entry prog_sel.
  - For base, yellow and walk, prog_val=0 stores that entry's default.
  - ext=0 is stored as-is and disables extension.
  - Every prog_en also restarts the controller at phase 0, GREEN, clears all walk latches, and restarts the prescaler.
  - The restarted interval uses the newly written value.
- Outputs are registered Moore decodes of state and phase. green, yellow and walk are never simultaneously nonzero.

## Timing
- Reset (async, g_reset=0): phase=0, state GREEN, green=1, yellow=0, walk=0, walk latches=0, prescaler=0, table=defaults.
- Release: the first GREEN interval counts from the first clk edge with g_reset=1.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - Tick is asserted when the count equals TICK_DIV-1.
  - The prescaler restarts at 0 on every state entry.
- Interval timer:
  - On state entry it is loaded with T.
  - It decrements on each tick.
  - The terminal tick is the tick with count=1; the transition occurs on that edge.
  - Each state therefore lasts exactly T×TICK_DIV clk cycles.
  - Outputs change on the same edge as the state change. There is zero extra latency beyond registering.
- sensor[phase] is sampled only on the GREEN terminal-tick cycle.
- walk_lat[phase] is sampled only on the YELLOW terminal-tick cycle. A request on that same cycle is honoured.
- Priority of simultaneous events: reset > prog_en > interval transition.
- Reset mid-state: immediate return to the reset values. Pending walk requests are lost.

## Test plan
Conditions for all scenarios: NUM_PHASES=2, TICK_DIV=4, defaults, sensor=0 unless noted.

- Plain cycle: release reset -> green=01 for 24 cycles, yellow=01 for 8, green=10 for 24, yellow=10 for 8, green=01 again with phase wrapped to 0.
- Extension: sensor[0]=1 throughout phase 0 -> green=01 for 24+12=36 cycles (one extension only), then yellow=01 for 8. sensor[1]=0 -> phase 1 green for 24.
- Walk: 1-cycle walk_req[1] pulse during phase 0 GREEN -> after phase 1 yellow, walk=10 with green=yellow=00 for 12 cycles, then green=01; the next cycle round has no walk.
- Walk during walk: walk_req[1] pulsed mid-WALK of phase 1 -> walk latch is set again, so the next cycle round includes a second phase 1 WALK.
- Reprogram: prog_en with prog_sel=2, prog_val=5 during phase 1 -> immediate green=01, phase=0; the next yellow lasts 20 cycles. prog_sel=0, prog_val=0 -> base reverts to 6 (24 cycles).
- Reset mid-yellow: g_reset=0 during phase 1 YELLOW -> outputs are green=01, yellow=00, walk=00, phase=0 asynchronously (before the next clk edge); after release the sequence matches the plain cycle.

Source files
------------

// File: rtl/multi_phase_signal_ctrl.sv
`default_nettype none
// ============================================================================
// multi_phase_signal_ctrl : N-phase green/extension/yellow/walk signal sequencer
// Rev 1.0 : initial release
// ============================================================================
module multi_phase_signal_ctrl #(
   parameter int NUM_PHASES = 2,
   parameter int TW         = 4,
   parameter int TICK_DIV   = 50000000,
   localparam int PW        = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                  clk,
   input  logic                  g_reset,
   input  logic [NUM_PHASES-1:0] sensor,
   input  logic [NUM_PHASES-1:0] walk_req,
   input  logic                  prog_en,
   input  logic [1:0]            prog_sel,
   input  logic [TW-1:0]         prog_val,
   output logic [NUM_PHASES-1:0] green,
   output logic [NUM_PHASES-1:0] yellow,
   output logic [NUM_PHASES-1:0] walk,
   output logic [PW-1:0]         phase
);

   localparam int CW = ($clog2(TICK_DIV) > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] c_PRE_MAX    = CW'(TICK_DIV - 1);
   localparam logic [PW-1:0] c_LAST_PHASE = PW'(NUM_PHASES - 1);

   localparam logic [1:0] c_GREEN     = 2'd0;
   localparam logic [1:0] c_GREEN_EXT = 2'd1;
   localparam logic [1:0] c_YELLOW    = 2'd2;
   localparam logic [1:0] c_WALK      = 2'd3;

   localparam logic [TW-1:0] c_DEF_BASE = TW'(6);
   localparam logic [TW-1:0] c_DEF_EXT  = TW'(3);
   localparam logic [TW-1:0] c_DEF_YEL  = TW'(2);
   localparam logic [TW-1:0] c_DEF_WALK = TW'(3);

   logic [1:0]            r_state;
   logic [PW-1:0]         r_phase;
   logic [CW-1:0]         r_pre;
   logic [TW-1:0]         r_timer;
   logic [TW-1:0]         r_base, r_ext, r_yel, r_walk_t;
   logic [NUM_PHASES-1:0] r_walk_lat;
   logic [NUM_PHASES-1:0] r_green, r_yellow, r_walk;

   logic                  w_tick, w_term;
   logic [PW-1:0]         w_phase_inc;
   logic [1:0]            w_state_nxt;
   logic [PW-1:0]         w_phase_nxt;
   logic                  w_load;
   logic [TW-1:0]         w_load_val;
   logic [TW-1:0]         w_prog_eff;
   logic [NUM_PHASES-1:0] w_onehot_cur, w_onehot_nxt, w_walk_clr;

   assign w_tick       = (r_pre == c_PRE_MAX);
   assign w_term       = w_tick && (r_timer == TW'(1));
   assign w_phase_inc  = (r_phase == c_LAST_PHASE) ? '0 : r_phase + PW'(1);
   assign w_onehot_cur = NUM_PHASES'(1) << r_phase;
   assign w_onehot_nxt = NUM_PHASES'(1) << w_phase_nxt;

   // A zero write restores the default, except extension where zero disables it
   always_comb begin
      w_prog_eff = prog_val;
      if (prog_val == '0) begin
         case (prog_sel)
            2'd0:    w_prog_eff = c_DEF_BASE;
            2'd2:    w_prog_eff = c_DEF_YEL;
            2'd3:    w_prog_eff = c_DEF_WALK;
            default: w_prog_eff = '0;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_load      = 1'b0;
      w_load_val  = r_base;
      if (prog_en) begin
         w_state_nxt = c_GREEN;
         w_phase_nxt = '0;
         w_load      = 1'b1;
         w_load_val  = (prog_sel == 2'd0) ? w_prog_eff : r_base;
      end else if (w_term) begin
         w_load = 1'b1;
         case (r_state)
            c_GREEN: begin
               if (sensor[r_phase] && (r_ext != '0)) begin
                  w_state_nxt = c_GREEN_EXT;
                  w_load_val  = r_ext;
               end else begin
                  w_state_nxt = c_YELLOW;
                  w_load_val  = r_yel;
               end
            end
            c_GREEN_EXT: begin
               w_state_nxt = c_YELLOW;
               w_load_val  = r_yel;
            end
            c_YELLOW: begin
               if (r_walk_lat[r_phase] || walk_req[r_phase]) begin
                  w_state_nxt = c_WALK;
                  w_load_val  = r_walk_t;
               end else begin
                  w_state_nxt = c_GREEN;
                  w_phase_nxt = w_phase_inc;
                  w_load_val  = r_base;
               end
            end
            default: begin
               w_state_nxt = c_GREEN;
               w_phase_nxt = w_phase_inc;
               w_load_val  = r_base;
            end
         endcase
      end
   end

   assign w_walk_clr = (!prog_en && (w_state_nxt == c_WALK) && (r_state != c_WALK))
                       ? w_onehot_cur : '0;

   always_ff @(posedge clk or negedge g_reset) begin
      if (!g_reset) begin
         r_state    <= c_GREEN;
         r_phase    <= '0;
         r_pre      <= '0;
         r_timer    <= c_DEF_BASE;
         r_base     <= c_DEF_BASE;
         r_ext      <= c_DEF_EXT;
         r_yel      <= c_DEF_YEL;
         r_walk_t   <= c_DEF_WALK;
         r_walk_lat <= '0;
         r_green    <= NUM_PHASES'(1);
         r_yellow   <= '0;
         r_walk     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;

         if (w_load || w_tick) r_pre <= '0;
         else                  r_pre <= r_pre + CW'(1);

         if (w_load)      r_timer <= w_load_val;
         else if (w_tick) r_timer <= r_timer - TW'(1);

         if (prog_en) begin
            case (prog_sel)
               2'd0:    r_base   <= w_prog_eff;
               2'd1:    r_ext    <= w_prog_eff;
               2'd2:    r_yel    <= w_prog_eff;
               default: r_walk_t <= w_prog_eff;
            endcase
         end

         // New requests win over the clear issued when a walk is entered
         if (prog_en) r_walk_lat <= '0;
         else         r_walk_lat <= (r_walk_lat & ~w_walk_clr) | walk_req;

         r_green  <= ((w_state_nxt == c_GREEN) || (w_state_nxt == c_GREEN_EXT))
                     ? w_onehot_nxt : '0;
         r_yellow <= (w_state_nxt == c_YELLOW) ? w_onehot_nxt : '0;
         r_walk   <= (w_state_nxt == c_WALK)   ? w_onehot_nxt : '0;
      end
   end

   assign green  = r_green;
   assign yellow = r_yellow;
   assign walk   = r_walk;
   assign phase  = r_phase;

endmodule
`default_nettype wire
